// File: rtl/joystick_spi_responder_if.sv
`timescale 1ns/1ps
// joystick_spi_responder_if
//   SPI bus between the joystick SPI master and the responder.
//   sck  : SPI clock, idle low (master -> slave)
//   cs   : active-low chip select (master -> slave)
//   mosi : master out, slave in
//   miso : master in, slave out
interface joystick_spi_responder_if;
  logic sck;
  logic cs;
  logic mosi;
  logic miso;

  modport master (output sck, output cs, output mosi, input miso);
  modport slave  (input sck, input cs, input mosi, output miso);
endinterface

// File: rtl/joystick_spi_responder.sv
`timescale 1ns/1ps
// joystick_spi_responder
//   SPI mode-0 slave (MSB first) standing in for the physical joystick.
//   Answers the joystick frame with x/y/button data latched at cs fall and
//   captures the LED command carried in the first received byte.
//
//   Ports:
//     clk50M     system clock, all logic on posedge
//     reset      synchronous, active-high
//     spi        SPI bus (slave modport): sck, cs, mosi in; miso out
//     x_in       10-bit x position to report
//     y_in       10-bit y position to report
//     btn_in     {btn2,btn1,jbtn}
//     led        {LD2,LD1} from the last valid LED command byte
//     frame_done 1-cycle pulse on cs rise after a complete frame
//     frame_err  sticky frame error flag
//
//   Build option: define JSTK_FRAME_CHECK_EN to build the frame checker that
//   drives frame_err; otherwise frame_err is tied low.
//
//   The master's SCK half-period must be at least SYNC_STAGES+2 clk cycles.
module joystick_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_BYTES   = 5
) (
  input  logic                           clk50M,
  input  logic                           reset,
  joystick_spi_responder_if.slave        spi,
  input  logic [9:0]                     x_in,
  input  logic [9:0]                     y_in,
  input  logic [2:0]                     btn_in,
  output logic [1:0]                     led,
  output logic                           frame_done,
  output logic                           frame_err
);

  localparam int BCW = $clog2(NUM_BYTES + 1);
  localparam logic [BCW-1:0] NB = BCW'(NUM_BYTES);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic       sck_d, cs_d;
  logic       sck_s, cs_s, mosi_s;
  logic       sck_rise, sck_fall, cs_rise, cs_fall;

  logic       start_frame, end_frame, rise_en, fall_en;

  logic [9:0] x_lat, y_lat;
  logic [2:0] btn_lat;
  logic [7:0] tx_sh;
  logic [6:0] rx_q;
  logic [7:0] rx_next;
  logic [2:0] bit_cnt;
  logic [BCW-1:0] byte_cnt, byte_cnt_inc;
  logic [7:0] next_byte;
  int         nb_idx;
  logic       miso_q;

  // Synchronisers plus one extra flop each on sck/cs for edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the synchroniser chain into a single stage.
  always_ff @(posedge clk50M) begin
    if (reset) begin
      // cs chain resets low so a frame in progress is not mistaken for idle.
      sck_sync  <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      cs_d      <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi.sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi.cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.mosi};
      sck_d     <= sck_s;
      cs_d      <= cs_s;
    end
  end

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign cs_rise  = cs_s & ~cs_d;
  assign cs_fall  = ~cs_s & cs_d;

  // FSM state register
  always_ff @(posedge clk50M) begin
    if (reset) state_q <= WAIT_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state and datapath strobes.
  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    rise_en     = 1'b0;
    fall_en     = 1'b0;
    unique case (state_q)
      WAIT_IDLE: if (cs_s) state_d = IDLE;
      IDLE: begin
        if (cs_fall) begin
          state_d     = SHIFT;
          start_frame = 1'b1;
        end
      end
      SHIFT: begin
        // cs rise takes priority over an sck edge in the same cycle.
        if (cs_rise) begin
          state_d   = IDLE;
          end_frame = 1'b1;
        end else begin
          rise_en = sck_rise;
          fall_en = sck_fall;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  assign rx_next      = {rx_q, mosi_s};
  assign byte_cnt_inc = (byte_cnt >= NB) ? NB : byte_cnt + 1'b1;
  assign nb_idx       = int'(byte_cnt_inc);

  // Byte to present after the current one completes; 0x00 past the frame.
  always_comb begin
    next_byte = 8'h00;
    if (nb_idx < NUM_BYTES) begin
      case (nb_idx)
        0:       next_byte = x_lat[7:0];
        1:       next_byte = {6'b0, x_lat[9:8]};
        2:       next_byte = y_lat[7:0];
        3:       next_byte = {6'b0, y_lat[9:8]};
        4:       next_byte = {5'b0, btn_lat};
        default: next_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk50M) begin
    if (reset) begin
      x_lat      <= '0;
      y_lat      <= '0;
      btn_lat    <= '0;
      tx_sh      <= '0;
      rx_q       <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      miso_q     <= 1'b0;
      led        <= 2'b00;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (start_frame) begin
        // Freeze the report for the whole frame and put B0[7] on miso now,
        // ahead of the master's first rising sck.
        x_lat    <= x_in;
        y_lat    <= y_in;
        btn_lat  <= btn_in;
        tx_sh    <= x_in[7:0];
        miso_q   <= x_in[7];
        rx_q     <= '0;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end
      if (end_frame) begin
        miso_q     <= 1'b0;
        frame_done <= (byte_cnt >= NB) && (bit_cnt == 3'd0);
      end
      if (rise_en) begin
        rx_q    <= rx_next[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          tx_sh    <= next_byte;
          byte_cnt <= byte_cnt_inc;
          if (byte_cnt == '0 && rx_next[7:2] == 6'b100000) led <= rx_next[1:0];
        end
      end
      if (fall_en) begin
        // bit_cnt==0 here means a byte boundary: present the freshly loaded
        // byte's MSB instead of shifting.
        if (bit_cnt == 3'd0) begin
          miso_q <= tx_sh[7];
        end else begin
          tx_sh  <= {tx_sh[6:0], 1'b0};
          miso_q <= tx_sh[6];
        end
      end
    end
  end

  assign spi.miso = miso_q;

`ifdef JSTK_FRAME_CHECK_EN
  // Short frame, partial byte, or a byte completing beyond the frame length.
  always_ff @(posedge clk50M) begin
    if (reset) begin
      frame_err <= 1'b0;
    end else if ((end_frame && (bit_cnt != 3'd0 || byte_cnt < NB)) ||
                 (rise_en && bit_cnt == 3'd7 && byte_cnt >= NB)) begin
      frame_err <= 1'b1;
    end
  end
`else
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_joystick_spi_responder.sv
`timescale 1ns/1ps
// tb_joystick_spi_responder
//   Drives the responder as a mode-0 SPI master and compares every read byte,
//   frame_done pulse count, led and frame_err against a reference model
//   derived from the frame layout (plain arithmetic on x/y/btn).
module tb_joystick_spi_responder;

  localparam int NUM_BYTES = 5;
  localparam int HALF      = 6;  // SCK half-period in clk cycles

  logic       clk50M = 1'b0;
  logic       reset;
  logic [9:0] x_in, y_in;
  logic [2:0] btn_in;
  logic [1:0] led;
  logic       frame_done, frame_err;

  joystick_spi_responder_if spi_if ();

  joystick_spi_responder #(
    .SYNC_STAGES(2),
    .NUM_BYTES  (NUM_BYTES)
  ) dut (
    .clk50M    (clk50M),
    .reset     (reset),
    .spi       (spi_if),
    .x_in      (x_in),
    .y_in      (y_in),
    .btn_in    (btn_in),
    .led       (led),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  always #10 clk50M = ~clk50M;

  int n_asserts = 0;
  int n_fail    = 0;
  int done_cnt  = 0;

  logic [7:0] mosi_buf [8];
  logic [7:0] miso_buf [8];
  logic [1:0] exp_led;
  logic       exp_err;

  // Counts cycles with frame_done high; a correct pulse adds exactly one.
  always @(negedge clk50M) if (frame_done === 1'b1) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk50M);
    #1;
  endtask

  // Reference frame: x low byte, x high bits, y low byte, y high bits, buttons.
  function automatic logic [7:0] model_byte(input int x, input int y, input int b, input int idx);
    case (idx)
      0:       return 8'(x % 256);
      1:       return 8'(x / 256);
      2:       return 8'(y % 256);
      3:       return 8'(y / 256);
      4:       return 8'(b);
      default: return 8'h00;
    endcase
  endfunction

  // Master transfer of nbits bits from mosi_buf, collecting miso into miso_buf.
  // Optionally changes x_in right after bit change_bit.
  task automatic spi_frame(input int nbits, input bit raise_cs, input int change_bit,
                           input logic [9:0] new_x);
    for (int i = 0; i < 8; i++) miso_buf[i] = 8'h00;
    spi_if.cs = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_if.mosi = mosi_buf[i / 8][7 - (i % 8)];
      wait_clk(HALF);
      miso_buf[i / 8][7 - (i % 8)] = spi_if.miso;
      spi_if.sck = 1'b1;
      wait_clk(HALF);
      spi_if.sck = 1'b0;
      if (i == change_bit) x_in = new_x;
    end
    if (raise_cs) begin
      wait_clk(HALF);
      spi_if.cs = 1'b1;
      wait_clk(HALF + 2);
    end
  endtask

  // Runs one framed transfer and checks it against the model.
  task automatic do_frame(input string tag, input int nbits, input int change_bit,
                          input logic [9:0] new_x);
    int xs, ys, bs, base;
    xs   = int'(x_in);
    ys   = int'(y_in);
    bs   = int'(btn_in);
    base = done_cnt;
    spi_frame(nbits, 1'b1, change_bit, new_x);
    for (int i = 0; i < nbits / 8; i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(miso_buf[i]), 32'(model_byte(xs, ys, bs, i)));
    if (nbits >= 8 && (int'(mosi_buf[0]) / 4) == 32) exp_led = 2'(int'(mosi_buf[0]) % 4);
`ifdef JSTK_FRAME_CHECK_EN
    if ((nbits % 8) != 0 || (nbits / 8) != NUM_BYTES) exp_err = 1'b1;
`endif
    check({tag, "_done"}, 32'(done_cnt - base),
          ((nbits % 8) == 0 && (nbits / 8) >= NUM_BYTES) ? 32'd1 : 32'd0);
    check({tag, "_led"}, 32'(led), 32'(exp_led));
    check({tag, "_err"}, 32'(frame_err), 32'(exp_err));
    check({tag, "_miso_idle"}, 32'(spi_if.miso), 32'd0);
  endtask

  initial begin
    int base;
    reset       = 1'b1;
    spi_if.sck  = 1'b0;
    spi_if.cs   = 1'b1;
    spi_if.mosi = 1'b0;
    x_in        = '0;
    y_in        = '0;
    btn_in      = '0;
    exp_led     = 2'b00;
    exp_err     = 1'b0;
    for (int i = 0; i < 8; i++) mosi_buf[i] = 8'h00;

    wait_clk(5);
    check("rst_miso", 32'(spi_if.miso), 32'd0);
    check("rst_led", 32'(led), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    wait_clk(10);

    // Basic frame: reads A5 02 7C 01 05, LED command 0x80 -> 00.
    x_in = 10'h2A5; y_in = 10'h17C; btn_in = 3'b101;
    mosi_buf[0] = 8'h80;
    do_frame("basic", 40, -1, '0);
    check("basic_b0_lit", 32'(miso_buf[0]), 32'h0000_00A5);
    check("basic_b4_lit", 32'(miso_buf[4]), 32'h0000_0005);

    // LED command accepted, then a non-command first byte leaves led alone.
    mosi_buf[0] = 8'h83;
    do_frame("led_on", 40, -1, '0);
    mosi_buf[0] = 8'h43;
    do_frame("led_keep", 40, -1, '0);

    // x changes mid-frame: this frame reports the old value, next the new.
    mosi_buf[0] = 8'h81;
    x_in = 10'h0F3;
    do_frame("x_mid", 40, 12, 10'h31C);
    do_frame("x_next", 40, -1, '0);

    // Randomized frames.
    for (int k = 0; k < 6; k++) begin
      x_in   = 10'($urandom_range(0, 1023));
      y_in   = 10'($urandom_range(0, 1023));
      btn_in = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) mosi_buf[0] = {6'b100000, 2'($urandom_range(0, 3))};
      else                           mosi_buf[0] = 8'($urandom);
      for (int i = 1; i < 8; i++) mosi_buf[i] = 8'($urandom);
      do_frame($sformatf("rand%0d", k), 40, -1, '0);
    end

    // Over-long frame: trailing bytes read 00, frame_done still pulses.
    x_in = 10'h3FF; y_in = 10'h201; btn_in = 3'b010;
    mosi_buf[0] = 8'h00;
    do_frame("long", 56, -1, '0);

    // Aborted after 13 bits: byte 0 LED command kept, no frame_done.
    mosi_buf[0] = 8'h82;
    do_frame("abort", 13, -1, '0);

    // Reset mid-frame at bit 20 with cs held low.
    mosi_buf[0] = 8'h81;
    spi_frame(20, 1'b0, -1, '0);
    check("pre_rst_led", 32'(led), 32'd1);
    reset = 1'b1;
    wait_clk(2);
    check("midrst_miso", 32'(spi_if.miso), 32'd0);
    check("midrst_led", 32'(led), 32'd0);
    check("midrst_err", 32'(frame_err), 32'd0);
    reset = 1'b0;
    wait_clk(2);
    exp_led = 2'b00;
    exp_err = 1'b0;
    // sck activity while cs has never been seen high must be ignored.
    base = done_cnt;
    mosi_buf[0] = 8'h83;
    spi_frame(8, 1'b1, -1, '0);
    check("ignored_miso", 32'(miso_buf[0]), 32'd0);
    check("ignored_led", 32'(led), 32'd0);
    check("ignored_done", 32'(done_cnt - base), 32'd0);

    x_in = 10'h155; y_in = 10'h2AA; btn_in = 3'b011;
    mosi_buf[0] = 8'h82;
    do_frame("post_rst", 40, -1, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
